// File: rtl/display_scheduler_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package display_scheduler_pkg;

   // Display owner states; ST_IDLE shows a blank display.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHOW_S = 2'd1,
      ST_SHOW_T = 2'd2,
      ST_ALERT  = 2'd3
   } state_e;

   localparam logic [3:0]  BLANK_CODE = 4'hF;
   localparam logic [31:0] BLANK_WORD = {8{BLANK_CODE}};

   // One-hot grant codes: [2]=alert, [1]=time, [0]=score.
   localparam logic [2:0] GNT_NONE  = 3'b000;
   localparam logic [2:0] GNT_SCORE = 3'b001;
   localparam logic [2:0] GNT_TIME  = 3'b010;
   localparam logic [2:0] GNT_ALERT = 3'b100;

   // Source selection from blank: score has priority over time.
   function automatic state_e idle_pick(input logic score_vld, input logic time_vld);
      state_e pick;
      if (score_vld) begin
         pick = ST_SHOW_S;
      end else if (time_vld) begin
         pick = ST_SHOW_T;
      end else begin
         pick = ST_IDLE;
      end
      return pick;
   endfunction

endpackage

// File: rtl/display_scheduler_tick_prescaler.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
module display_scheduler_tick_prescaler #(
   parameter int TICK_DIV = 100_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int            CW   = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_r;

   // Count 0..TICK_DIV-1 and wrap explicitly; never restarted by the scheduler.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r <= '0;
      end else if (cnt_r == LAST) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CW'(1'b1);
      end
   end

   assign tick = (cnt_r == LAST);

endmodule

// File: rtl/display_scheduler.sv
// Time-shares the 8-digit display between alert, score and time sources.
module display_scheduler
   import display_scheduler_pkg::*;
#(
   parameter int TICK_DIV    = 100_000,
   parameter int ROT_TICKS   = 3000,
   parameter int ALERT_TICKS = 2000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alert_req,
   input  logic [31:0] alert_data,
   input  logic        score_vld,
   input  logic [31:0] score_data,
   input  logic        time_vld,
   input  logic [31:0] time_data,
   output logic [3:0]  dig7,
   output logic [3:0]  dig6,
   output logic [3:0]  dig5,
   output logic [3:0]  dig4,
   output logic [3:0]  dig3,
   output logic [3:0]  dig2,
   output logic [3:0]  dig1,
   output logic [3:0]  dig0,
   output logic [2:0]  gnt,
   output logic        alert_busy
);

   localparam int            HOLD_MAX   = (ROT_TICKS > ALERT_TICKS) ? ROT_TICKS : ALERT_TICKS;
   localparam int            HW         = $clog2(HOLD_MAX + 1);
   localparam logic [HW-1:0] ROT_LAST   = HW'(ROT_TICKS - 1);
   localparam logic [HW-1:0] ALERT_LAST = HW'(ALERT_TICKS - 1);

   logic          tick_s;
   state_e        state_r,  state_s;
   state_e        resume_r, resume_s;
   logic [HW-1:0] hold_r,   hold_s;
   logic [31:0]   alert_r,  alert_s;
   logic [31:0]   disp_r,   disp_s;
   logic [2:0]    gnt_r,    gnt_s;
   logic          busy_r,   busy_s;

   display_scheduler_tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_prescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (tick_s)
   );

   // State, resume target, hold counter and alert latch registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= ST_IDLE;
         resume_r <= ST_IDLE;
         hold_r   <= '0;
         alert_r  <= 32'h0000_0000;
      end else begin
         state_r  <= state_s;
         resume_r <= resume_s;
         hold_r   <= hold_s;
         alert_r  <= alert_s;
      end
   end

   // Next-state logic: alert pre-empts everything, then vld loss, then rotation expiry.
   always_comb begin
      state_s  = state_r;
      resume_s = resume_r;
      hold_s   = hold_r;
      alert_s  = alert_r;
      if (alert_req) begin
         // A re-trigger keeps the resume target of the original interruption.
         state_s = ST_ALERT;
         hold_s  = '0;
         alert_s = alert_data;
         if (state_r != ST_ALERT) begin
            resume_s = state_r;
         end else begin
            resume_s = resume_r;
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               hold_s  = '0;
               state_s = idle_pick(score_vld, time_vld);
            end
            ST_SHOW_S: begin
               if (!score_vld) begin
                  hold_s  = '0;
                  state_s = time_vld ? ST_SHOW_T : ST_IDLE;
               end else if (tick_s) begin
                  if (hold_r == ROT_LAST) begin
                     hold_s  = '0;
                     state_s = time_vld ? ST_SHOW_T : ST_SHOW_S;
                  end else begin
                     hold_s = hold_r + HW'(1'b1);
                  end
               end else begin
                  hold_s = hold_r;
               end
            end
            ST_SHOW_T: begin
               if (!time_vld) begin
                  hold_s  = '0;
                  state_s = score_vld ? ST_SHOW_S : ST_IDLE;
               end else if (tick_s) begin
                  if (hold_r == ROT_LAST) begin
                     hold_s  = '0;
                     state_s = score_vld ? ST_SHOW_S : ST_SHOW_T;
                  end else begin
                     hold_s = hold_r + HW'(1'b1);
                  end
               end else begin
                  hold_s = hold_r;
               end
            end
            ST_ALERT: begin
               if (tick_s) begin
                  if (hold_r == ALERT_LAST) begin
                     hold_s = '0;
                     case (resume_r)
                        ST_SHOW_S: state_s = score_vld ? ST_SHOW_S : idle_pick(score_vld, time_vld);
                        ST_SHOW_T: state_s = time_vld  ? ST_SHOW_T : idle_pick(score_vld, time_vld);
                        default:   state_s = ST_IDLE;
                     endcase
                  end else begin
                     hold_s = hold_r + HW'(1'b1);
                  end
               end else begin
                  hold_s = hold_r;
               end
            end
            default: begin
               hold_s  = '0;
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // Output mux: score/time pass through live while granted, alert comes from the latch.
   always_comb begin
      disp_s = BLANK_WORD;
      gnt_s  = GNT_NONE;
      busy_s = 1'b0;
      case (state_r)
         ST_SHOW_S: begin
            disp_s = score_data;
            gnt_s  = GNT_SCORE;
         end
         ST_SHOW_T: begin
            disp_s = time_data;
            gnt_s  = GNT_TIME;
         end
         ST_ALERT: begin
            disp_s = alert_r;
            gnt_s  = GNT_ALERT;
            busy_s = 1'b1;
         end
         default: begin
            disp_s = BLANK_WORD;
            gnt_s  = GNT_NONE;
            busy_s = 1'b0;
         end
      endcase
   end

   // Output registers: digits, grant and busy all change on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         disp_r <= BLANK_WORD;
         gnt_r  <= GNT_NONE;
         busy_r <= 1'b0;
      end else begin
         disp_r <= disp_s;
         gnt_r  <= gnt_s;
         busy_r <= busy_s;
      end
   end

   assign dig7       = disp_r[31:28];
   assign dig6       = disp_r[27:24];
   assign dig5       = disp_r[23:20];
   assign dig4       = disp_r[19:16];
   assign dig3       = disp_r[15:12];
   assign dig2       = disp_r[11:8];
   assign dig1       = disp_r[7:4];
   assign dig0       = disp_r[3:0];
   assign gnt        = gnt_r;
   assign alert_busy = busy_r;

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler with a behavioural owner/tick model.
module tb_display_scheduler;

   localparam int TD = 4;
   localparam int RT = 3;
   localparam int AT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        alert_req;
   logic [31:0] alert_data;
   logic        score_vld;
   logic [31:0] score_data;
   logic        time_vld;
   logic [31:0] time_data;
   logic [3:0]  dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0;
   logic [2:0]  gnt;
   logic        alert_busy;
   logic [31:0] disp;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   // Model: owner 0=blank 1=score 2=time 3=alert; ticks counted since owner took over.
   int          m_own, m_res, m_ticks, m_clk;
   logic [31:0] m_alert;

   assign disp = {dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0};

   always #5 clk = ~clk;

   display_scheduler #(
      .TICK_DIV    (TD),
      .ROT_TICKS   (RT),
      .ALERT_TICKS (AT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .alert_req  (alert_req),
      .alert_data (alert_data),
      .score_vld  (score_vld),
      .score_data (score_data),
      .time_vld   (time_vld),
      .time_data  (time_data),
      .dig7       (dig7),
      .dig6       (dig6),
      .dig5       (dig5),
      .dig4       (dig4),
      .dig3       (dig3),
      .dig2       (dig2),
      .dig1       (dig1),
      .dig0       (dig0),
      .gnt        (gnt),
      .alert_busy (alert_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_own = 0; m_res = 0; m_ticks = 0; m_clk = 0; m_alert = 32'h0;
   endtask

   function automatic int pick(input logic s, input logic t);
      return s ? 1 : (t ? 2 : 0);
   endfunction

   // One clock: derive expected outputs from the pre-edge model, advance model, compare.
   task automatic cyc();
      logic [31:0] e_disp;
      logic [2:0]  e_gnt;
      logic        e_busy;
      bit          tk;
      @(posedge clk);
      if (!rst) begin
         model_reset();
         e_disp = 32'hFFFF_FFFF; e_gnt = 3'b000; e_busy = 1'b0;
      end else begin
         e_gnt  = (m_own == 0) ? 3'b000 : 3'(1 << ((m_own == 3) ? 2 : m_own - 1));
         e_busy = (m_own == 3);
         e_disp = (m_own == 1) ? score_data : (m_own == 2) ? time_data :
                  (m_own == 3) ? m_alert : 32'hFFFF_FFFF;
         tk    = ((m_clk % TD) == TD - 1);
         m_clk = m_clk + 1;
         if (alert_req) begin
            if (m_own != 3) m_res = m_own;
            m_own = 3; m_ticks = 0; m_alert = alert_data;
         end else if (m_own == 0) begin
            m_own = pick(score_vld, time_vld); m_ticks = 0;
         end else if (m_own == 3) begin
            if (tk) m_ticks++;
            if (m_ticks == AT) begin
               m_ticks = 0;
               if (m_res == 1 && score_vld) m_own = 1;
               else if (m_res == 2 && time_vld) m_own = 2;
               else if (m_res == 0) m_own = 0;
               else m_own = pick(score_vld, time_vld);
            end
         end else begin
            // Rotating source: m_own 1 or 2, the other one is 3 - m_own.
            if (!((m_own == 1) ? score_vld : time_vld)) begin
               m_own = ((m_own == 1) ? time_vld : score_vld) ? 3 - m_own : 0;
               m_ticks = 0;
            end else begin
               if (tk) m_ticks++;
               if (m_ticks == RT) begin
                  m_ticks = 0;
                  if ((m_own == 1) ? time_vld : score_vld) m_own = 3 - m_own;
               end
            end
         end
      end
      #1;
      cyc_n++;
      chk("digits", disp, e_disp);
      chk("gnt", {29'd0, gnt}, {29'd0, e_gnt});
      chk("alert_busy", {31'd0, alert_busy}, {31'd0, e_busy});
      chk("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
   endtask

   task automatic wait_gnt(input logic [2:0] t, input int budget);
      int n = 0;
      while (gnt !== t && n < budget) begin
         cyc();
         n++;
      end
      chk("wait_gnt", {29'd0, gnt}, {29'd0, t});
   endtask

   // Count cycles with alert shown, starting at the current (already busy) cycle.
   task automatic busy_len(output int n);
      n = 0;
      while (gnt === 3'b100 && n < 40) begin
         n++;
         cyc();
      end
   endtask

   initial begin
      int          last_chg, nchg, run, n;
      logic [2:0]  prev;

      rst = 1'b0; alert_req = 1'b0; alert_data = 32'h0;
      score_vld = 1'b0; score_data = 32'h0; time_vld = 1'b0; time_data = 32'h0;
      model_reset();
      #12;
      chk("reset_digits", disp, 32'hFFFF_FFFF);
      chk("reset_gnt", {29'd0, gnt}, 32'd0);
      chk("reset_busy", {31'd0, alert_busy}, 32'd0);
      #11 rst = 1'b1;

      // Both sources invalid: display stays blank.
      for (int i = 0; i < 10; i++) cyc();
      chk("idle_blank", disp, 32'hFFFF_FFFF);

      // Rotation between score and time.
      score_data = 32'h0000_1234; time_data = 32'h0001_0203;
      score_vld = 1'b1; time_vld = 1'b1;
      last_chg = -1; nchg = 0; prev = gnt;
      for (int i = 0; i < 70; i++) begin
         cyc();
         if (gnt !== prev) begin
            if (prev !== 3'b000 && last_chg >= 0) begin
               run = cyc_n - last_chg;
               chk("rot_len_ok", {31'd0, (run >= 8 && run <= 16)}, 32'd1);
               nchg++;
            end
            last_chg = cyc_n;
            prev = gnt;
         end
      end
      chk("rot_switches", {31'd0, (nchg >= 4)}, 32'd1);

      // Alert from score, with resume back to score.
      time_vld = 1'b0;
      wait_gnt(3'b001, 30);
      cyc();
      alert_req = 1'b1; alert_data = 32'hABCD_EF01;
      cyc();
      alert_req = 1'b0; alert_data = 32'h0;
      cyc();
      chk("alert_gnt", {29'd0, gnt}, 32'd4);
      chk("alert_digits", disp, 32'hABCD_EF01);
      busy_len(n);
      chk("alert_len_ok", {31'd0, (n >= 5 && n <= 8)}, 32'd1);
      chk("alert_resume", {29'd0, gnt}, 32'd1);

      // Re-trigger inside an alert restarts the duration and keeps the score resume.
      cyc();
      alert_req = 1'b1; alert_data = 32'h5A5A_0F0F;
      cyc();
      alert_req = 1'b0;
      cyc(); cyc();
      alert_req = 1'b1; alert_data = 32'h1111_1111;
      cyc();
      alert_req = 1'b0; alert_data = 32'h0;
      cyc();
      chk("retrig_digits", disp, 32'h1111_1111);
      busy_len(n);
      chk("retrig_len_ok", {31'd0, (n >= 5 && n <= 8)}, 32'd1);
      chk("retrig_resume", {29'd0, gnt}, 32'd1);

      // Time loses vld with score absent: blank, then score takes over.
      time_vld = 1'b1; score_vld = 1'b0;
      wait_gnt(3'b010, 30);
      time_vld = 1'b0;
      cyc(); cyc();
      chk("drop_gnt", {29'd0, gnt}, 32'd0);
      chk("drop_digits", disp, 32'hFFFF_FFFF);
      score_vld = 1'b1;
      cyc(); cyc();
      chk("rise_gnt", {29'd0, gnt}, 32'd1);

      // Randomised traffic against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(7) == 0) score_vld = ~score_vld;
         if ($urandom_range(7) == 0) time_vld  = ~time_vld;
         alert_req  = ($urandom_range(39) == 0);
         alert_data = $urandom;
         score_data = $urandom;
         time_data  = $urandom;
         cyc();
      end
      alert_req = 1'b0;

      // Reset mid-alert: immediate clear, no resume of the alert afterwards.
      score_vld = 1'b1; time_vld = 1'b0;
      alert_req = 1'b1; alert_data = 32'hDEAD_BEEF;
      cyc();
      alert_req = 1'b0;
      cyc(); cyc();
      chk("pre_rst_busy", {31'd0, alert_busy}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("arst_digits", disp, 32'hFFFF_FFFF);
      chk("arst_gnt", {29'd0, gnt}, 32'd0);
      chk("arst_busy", {31'd0, alert_busy}, 32'd0);
      model_reset();
      cyc(); cyc(); cyc();
      rst = 1'b1;
      cyc(); cyc();
      chk("post_rst_gnt", {29'd0, gnt}, 32'd1);
      for (int i = 0; i < 12; i++) begin
         cyc();
         chk("post_rst_no_alert", {31'd0, alert_busy}, 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Time-shares the 8-digit seven-segment display between three content sources: a one-shot alert (e.g. "GAME OVER", "HIT"), the score readout and the elapsed-time readout. The block rotates between score and time on a fixed tick schedule and pre-empts both for a timed alert. It then resumes the interrupted source. It sits between the game logic and the segment display driver, and drives that driver's eight 4-bit digit inputs.

## Interface
- TICK_DIV, 100_000, clk cycles per scheduler tick (≥2)
- ROT_TICKS, 3000, ticks each rotating source is held before switching
- ALERT_TICKS, 2000, ticks an alert is shown
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- alert_req  in  1  one-cycle pulse: show alert_data
- alert_data  in  32  alert digits, [31:28]=dig7 … [3:0]=dig0
- score_vld  in  1  level: score content available
- score_data  in  32  score digits, same packing
- time_vld  in  1  level: time content available
- time_data  in  32  time digits, same packing
- dig7..dig0  out  4 each  registered digit codes to the display driver
- gnt  out  3  one-hot owner: [2]=alert, [1]=time, [0]=score; 000 = blank
- alert_busy  out  1  high while alert is displayed

## Operation
- States: IDLE (blank), SHOW_S (score), SHOW_T (time), ALERT.
- Outputs in IDLE: all digits = BLANK_CODE (4'hF), gnt=000.
- A prescaler emits a one-cycle tick every TICK_DIV clocks. The hold counter counts ticks only.
- The alert data is latched on acceptance. The score and time data pass through live and are registered every cycle while granted.
- IDLE transitions:
  - to SHOW_S if score_vld;
  - else to SHOW_T if time_vld.
- SHOW_S/SHOW_T:
  - When the hold counter reaches ROT_TICKS, switch to the other source if it is valid; otherwise stay and restart the count.
  - If the current source's vld drops, move next cycle to the other source if it is valid, else to IDLE. The hold counter resets.
- ALERT is entered from any state on alert_req. It latches alert_data and records the resume target:
  - resume = current state;
  - IDLE resumes to IDLE.
- ALERT exit: after ALERT_TICKS ticks, go to the resume target if its vld is still high. Otherwise apply the IDLE selection rule. The hold counter resets.
- alert_req while in ALERT re-triggers: it latches the new data, restarts the count and keeps the original resume target.
- Simultaneous events:
  - alert_req in the same cycle as rotation expiry: alert wins. The resume target is the pre-rotation source.
  - alert_req in the same cycle as ALERT expiry: re-trigger.
- Prescaler is free-running and never reset by state changes, so the first hold period after any transition is ROT_TICKS−1 to ROT_TICKS ticks.

## Timing
- Reset (async): state=IDLE, digits=4'hF, gnt=000, alert_busy=0, all counters 0.
- Outputs are registered. A request or vld change sampled at edge N is visible on the outputs after edge N+1 (1-cycle latency).
- alert_busy is high from the cycle gnt[2] rises until the cycle gnt[2] falls. It is exactly aligned with gnt[2].
- gnt is always one-hot or zero. Digits and gnt change on the same edge.
- Counter widths: prescaler $clog2(TICK_DIV); hold counter $clog2(max(ROT_TICKS,ALERT_TICKS)+1). Neither wraps; both are compared with ==.
- Reset asserted mid-alert: alert is lost, with no resume after deassertion. The first grant follows the IDLE rule one cycle after the first clock edge following deassertion.

## Structure
- Shared package entries: state enum (IDLE, SHOW_S, SHOW_T, ALERT), BLANK_CODE=4'hF, GNT_* one-hot constants.
- One sub-module: tick_prescaler (parameter TICK_DIV; outputs a one-cycle tick).
- The top level holds the FSM, hold counter, alert latch and output mux/registers.

## Test plan
All scenarios use TICK_DIV=4, ROT_TICKS=3, ALERT_TICKS=2.
- Reset, both vld low → digits all F, gnt=000, alert_busy=0 indefinitely.
- score_vld=time_vld=1, score_data=32'h0000_1234, time_data=32'h0001_0203 → gnt alternates 001/010 every 12±4 clocks; digits track the granted data.
- In SHOW_S, pulse alert_req with 32'hABCD_EF01 → next cycle gnt=100, digits ABCDEF01, alert_busy=1 for 8±4 clocks, then returns to gnt=001.
- In ALERT, pulse alert_req again with 32'h1111_1111 → digits 11111111, duration restarts, resume remains score.
- In SHOW_T, drop time_vld with score_vld=0 → next cycle gnt=000, digits F; raise score_vld → gnt=001 one cycle later.
- Assert rst mid-alert → same cycle (async) all outputs at reset values; after release no alert is shown.
